// File: rtl/bram_read_align_if.sv
// rtl/bram_read_align_if.sv - Handshake and data bundle for bram_read_align
//
// Groups every non-clock, non-reset signal of bram_read_align.
//   start_i, rd_valid_i, done_decode_i : stage control from the address decoder
//   index_a_i, index_b_i               : 8 x 3-bit bank index per BU (BU0 in LSBs)
//   bram_dout_a_i, bram_dout_b_i       : 8 x DATA_WIDTH bank read data (bank0 in LSBs)
//   bu_a_o, bu_b_o, out_valid_o        : routed operands per BU and their valid
//   beat_cnt_o, busy_o, conflict_o, done_o : status
// master drives the inputs and observes the outputs; slave is the aligner.
interface bram_read_align_if #(
    parameter int DATA_WIDTH = 12
);
    logic                      start_i;
    logic                      rd_valid_i;
    logic [23:0]               index_a_i;
    logic [23:0]               index_b_i;
    logic                      done_decode_i;
    logic [8*DATA_WIDTH-1:0]   bram_dout_a_i;
    logic [8*DATA_WIDTH-1:0]   bram_dout_b_i;
    logic [8*DATA_WIDTH-1:0]   bu_a_o;
    logic [8*DATA_WIDTH-1:0]   bu_b_o;
    logic                      out_valid_o;
    logic [7:0]                beat_cnt_o;
    logic                      busy_o;
    logic                      conflict_o;
    logic                      done_o;

    modport master (
        output start_i, rd_valid_i, index_a_i, index_b_i, done_decode_i,
               bram_dout_a_i, bram_dout_b_i,
        input  bu_a_o, bu_b_o, out_valid_o, beat_cnt_o, busy_o, conflict_o, done_o
    );

    modport slave (
        input  start_i, rd_valid_i, index_a_i, index_b_i, done_decode_i,
               bram_dout_a_i, bram_dout_b_i,
        output bu_a_o, bu_b_o, out_valid_o, beat_cnt_o, busy_o, conflict_o, done_o
    );
endinterface

// File: rtl/bram_read_align.sv
// rtl/bram_read_align.sv - Align banked BRAM read data to butterfly units
//
// Carries each accepted beat's bank indices through a BRAM_LAT-deep pipe so
// they line up with the BRAM read data, then routes bank data to each BU and
// registers the result (beat -> out_valid_o latency is BRAM_LAT+1).
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : bram_read_align_if.slave (control, indices, BRAM data, outputs)
// Optional: define BRAM_CONFLICT_CHECK_EN to enable the sticky conflict_o
// flag (duplicate bank within one port's indices); otherwise conflict_o = 0.
module bram_read_align #(
    parameter int DATA_WIDTH = 12,
    parameter int BRAM_LAT   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bram_read_align_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int         LAST    = BRAM_LAT - 1;

    logic [1:0]              state;
    logic [2:0]              drain_cnt;
    logic                    accept;
    logic                    start_ok;
    logic [7:0]              beat_cnt_q;

    logic                    pipe_vld [BRAM_LAT];
    logic [23:0]             pipe_ia  [BRAM_LAT];
    logic [23:0]             pipe_ib  [BRAM_LAT];

    logic [DATA_WIDTH-1:0]   bank_a [8];
    logic [DATA_WIDTH-1:0]   bank_b [8];
    logic [8*DATA_WIDTH-1:0] bu_a_q;
    logic [8*DATA_WIDTH-1:0] bu_b_q;
    logic                    out_valid_q;

    assign accept   = (state == S_RUN) && bus.rd_valid_i;
    assign start_ok = (state == S_IDLE) && bus.start_i;

    // DRAIN counts BRAM_LAT..0 so the last beat's output has left before DONE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start_i) state <= S_RUN;
                S_RUN: begin
                    if (bus.done_decode_i) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 3'(BRAM_LAT);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 3'd0) state <= S_DONE;
                    else                   drain_cnt <= drain_cnt - 3'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            beat_cnt_q <= '0;
        end else if (start_ok) begin
            beat_cnt_q <= '0;
        end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
        end
    end

    // Index pipe: stage LAST is aligned with the cycle the BRAM presents data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < BRAM_LAT; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_ia[k]  <= '0;
                pipe_ib[k]  <= '0;
            end
        end else begin
            pipe_vld[0] <= accept;
            pipe_ia[0]  <= bus.index_a_i;
            pipe_ib[0]  <= bus.index_b_i;
            for (int k = 1; k < BRAM_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_ia[k]  <= pipe_ia[k-1];
                pipe_ib[k]  <= pipe_ib[k-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            bank_a[k] = bus.bram_dout_a_i[k*DATA_WIDTH +: DATA_WIDTH];
            bank_b[k] = bus.bram_dout_b_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Full crossbar: several BUs may pick the same bank and all get its data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bu_a_q      <= '0;
            bu_b_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= pipe_vld[LAST];
            if (pipe_vld[LAST]) begin
                for (int i = 0; i < 8; i++) begin
                    bu_a_q[i*DATA_WIDTH +: DATA_WIDTH] <= bank_a[pipe_ia[LAST][i*3 +: 3]];
                    bu_b_q[i*DATA_WIDTH +: DATA_WIDTH] <= bank_b[pipe_ib[LAST][i*3 +: 3]];
                end
            end
        end
    end

`ifdef BRAM_CONFLICT_CHECK_EN
    logic dup_a;
    logic dup_b;
    logic conflict_q;

    // Only duplicates within one port matter; A and B read separate ports.
    always_comb begin
        dup_a = 1'b0;
        dup_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                if (bus.index_a_i[i*3 +: 3] == bus.index_a_i[j*3 +: 3]) dup_a = 1'b1;
                if (bus.index_b_i[i*3 +: 3] == bus.index_b_i[j*3 +: 3]) dup_b = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            conflict_q <= 1'b0;
        end else if (start_ok) begin
            conflict_q <= 1'b0;
        end else if (accept && (dup_a || dup_b)) begin
            conflict_q <= 1'b1;
        end
    end

    assign bus.conflict_o = conflict_q;
`else
    assign bus.conflict_o = 1'b0;
`endif

    assign bus.bu_a_o      = bu_a_q;
    assign bus.bu_b_o      = bu_b_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.beat_cnt_o  = beat_cnt_q;
    assign bus.busy_o      = (state != S_IDLE);
    assign bus.done_o      = (state == S_DONE);

endmodule

// File: tb/tb_bram_read_align.sv
// tb/tb_bram_read_align.sv - Self-checking bench for bram_read_align
module tb_bram_read_align;

    localparam int DW  = 12;
    localparam int L   = 2;
    localparam int BIG = 1000000000;
`ifdef BRAM_CONFLICT_CHECK_EN
    localparam bit CONF_EN = 1'b1;
`else
    localparam bit CONF_EN = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [23:0] ia;
        logic [23:0] ib;
    } beat_t;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    bram_read_align_if #(.DATA_WIDTH(DW)) bus ();

    bram_read_align #(.DATA_WIDTH(DW), .BRAM_LAT(L)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int          n_pass;
    int          n_fail;
    int          n_total;
    int          cyc;
    int          run_start;
    int          run_end;
    int          m_beats;
    bit          m_conf;
    bit          fixed_data;
    beat_t       q[$];
    logic [95:0] hist_a [64];
    logic [95:0] hist_b [64];
    logic [95:0] hold_a;
    logic [95:0] hold_b;
    logic [23:0] perm_rev;
    logic [23:0] perm_id;
    logic [23:0] dup_a;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] route(input logic [95:0] data, input logic [23:0] idx);
        logic [95:0] r;
        int b;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            b = int'(idx[i*3 +: 3]);
            r[i*DW +: DW] = data[b*DW +: DW];
        end
        return r;
    endfunction

    function automatic bit has_dup(input logic [23:0] idx);
        bit d;
        d = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int j = i + 1; j < 8; j++)
                if (idx[i*3 +: 3] == idx[j*3 +: 3]) d = 1'b1;
        return d;
    endfunction

    task automatic check_all(input int c);
        bit ev;
        ev = 1'b0;
        if (q.size() > 0 && q[0].due == c) begin
            ev     = 1'b1;
            hold_a = route(hist_a[(c-1) % 64], q[0].ia);
            hold_b = route(hist_b[(c-1) % 64], q[0].ib);
            void'(q.pop_front());
        end
        chk("out_valid", 96'(bus.out_valid_o), 96'(ev));
        chk("bu_a", bus.bu_a_o, hold_a);
        chk("bu_b", bus.bu_b_o, hold_b);
        chk("beat_cnt", 96'(bus.beat_cnt_o), 96'(m_beats));
        chk("busy", 96'(bus.busy_o), 96'(c >= run_start && c <= run_end + L + 2));
        chk("done", 96'(bus.done_o), 96'(c == run_end + L + 2));
        chk("conflict", 96'(bus.conflict_o), 96'(m_conf));
    endtask

    task automatic tick(input bit st, input bit rv, input bit dd,
                        input logic [23:0] ia, input logic [23:0] ib);
        int          t;
        bit          in_run;
        bit          idle;
        logic [95:0] da;
        logic [95:0] db;
        t = cyc;
        for (int k = 0; k < 8; k++) begin
            if (fixed_data) begin
                da[k*DW +: DW] = 12'(256 + k);
                db[k*DW +: DW] = 12'(512 + k);
            end else begin
                da[k*DW +: DW] = 12'($urandom);
                db[k*DW +: DW] = 12'($urandom);
            end
        end
        bus.start_i       = st;
        bus.rd_valid_i    = rv;
        bus.done_decode_i = dd;
        bus.index_a_i     = ia;
        bus.index_b_i     = ib;
        bus.bram_dout_a_i = da;
        bus.bram_dout_b_i = db;
        hist_a[t % 64]    = da;
        hist_b[t % 64]    = db;

        in_run = (t >= run_start) && (t <= run_end);
        idle   = !((t >= run_start) && (t <= run_end + L + 2));
        if (idle && st) begin
            run_start = t + 1;
            run_end   = BIG;
            m_beats   = 0;
            m_conf    = 1'b0;
        end
        if (in_run && rv) begin
            q.push_back('{due: t + L + 1, ia: ia, ib: ib});
            m_beats = (m_beats + 1) % 256;
            if (CONF_EN && (has_dup(ia) || has_dup(ib))) m_conf = 1'b1;
        end
        if (in_run && dd) run_end = t;

        @(posedge clk_i);
        #1;
        cyc++;
        check_all(cyc);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst_i             = 1'b0;
        bus.start_i       = 1'b0;
        bus.rd_valid_i    = 1'b0;
        bus.done_decode_i = 1'b0;
        bus.index_a_i     = '0;
        bus.index_b_i     = '0;
        bus.bram_dout_a_i = '0;
        bus.bram_dout_b_i = '0;
        #1;
        chk("rst_out_valid", 96'(bus.out_valid_o), 96'(0));
        chk("rst_bu_a", bus.bu_a_o, 96'(0));
        chk("rst_bu_b", bus.bu_b_o, 96'(0));
        chk("rst_beat_cnt", 96'(bus.beat_cnt_o), 96'(0));
        chk("rst_busy", 96'(bus.busy_o), 96'(0));
        chk("rst_done", 96'(bus.done_o), 96'(0));
        chk("rst_conflict", 96'(bus.conflict_o), 96'(0));
        @(posedge clk_i);
        #1;
        cyc++;
        q.delete();
        run_start = 0;
        run_end   = -100;
        m_beats   = 0;
        m_conf    = 1'b0;
        hold_a    = '0;
        hold_b    = '0;
        check_all(cyc);
        rst_i = 1'b1;
    endtask

    initial begin
        n_pass     = 0;
        n_fail     = 0;
        n_total    = 0;
        cyc        = 0;
        fixed_data = 1'b0;
        for (int i = 0; i < 8; i++) begin
            perm_rev[i*3 +: 3] = 3'(7 - i);
            perm_id[i*3 +: 3]  = 3'(i);
        end
        dup_a = perm_id;
        dup_a[0 +: 3] = 3'd2;
        dup_a[6 +: 3] = 3'd0;
        dup_a[9 +: 3] = 3'd2;
        rst_i = 1'b1;
        #2;
        do_reset();
        idle_ticks(2);

        // single beat, bank k returns 0x100+k, BU i reads bank 7-i
        fixed_data = 1'b1;
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        tick(1'b0, 1'b1, 1'b1, perm_rev, perm_id);
        idle_ticks(2);
        chk("single_valid", 96'(bus.out_valid_o), 96'(1));
        chk("single_bu0", 96'(bus.bu_a_o[11:0]), 96'(12'h107));
        chk("single_bu7", 96'(bus.bu_a_o[95:84]), 96'(12'h100));
        idle_ticks(1);
        chk("single_done", 96'(bus.done_o), 96'(1));
        idle_ticks(1);
        chk("single_idle", 96'(bus.busy_o), 96'(0));
        fixed_data = 1'b0;

        // 16 back-to-back beats, done_decode with the last
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 16; i++)
            tick(1'b0, 1'b1, (i == 15), 24'($urandom), 24'($urandom));
        chk("b16_cnt", 96'(bus.beat_cnt_o), 96'(16));
        idle_ticks(L + 3);

        // gaps; rd_valid in IDLE/DRAIN and start in RUN are ignored
        tick(1'b0, 1'b1, 1'b0, 24'($urandom), 24'($urandom));
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 30; i++)
            tick((i == 10), 1'($urandom_range(0, 1)), (i == 29), 24'($urandom), 24'($urandom));
        for (int i = 0; i < L + 4; i++)
            tick(1'b0, 1'b1, 1'b0, 24'($urandom), 24'($urandom));

        // conflict detection and clearing
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        tick(1'b0, 1'b1, 1'b0, perm_id, perm_rev);
        tick(1'b0, 1'b1, 1'b0, dup_a, perm_id);
        tick(1'b0, 1'b0, 1'b1, '0, '0);
        idle_ticks(L + 3);
        chk("conf_held", 96'(bus.conflict_o), 96'(CONF_EN));
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        chk("conf_clear", 96'(bus.conflict_o), 96'(0));
        tick(1'b0, 1'b1, 1'b1, perm_rev, perm_rev);
        idle_ticks(L + 3);
        chk("conf_perm", 96'(bus.conflict_o), 96'(0));

        // reset with two beats in flight
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        tick(1'b0, 1'b1, 1'b0, 24'($urandom), 24'($urandom));
        tick(1'b0, 1'b1, 1'b0, 24'($urandom), 24'($urandom));
        do_reset();
        idle_ticks(L + 4);

        // 300 beats wrap the counter to 44
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 300; i++)
            tick(1'b0, 1'b1, (i == 299), 24'($urandom), 24'($urandom));
        chk("wrap_cnt", 96'(bus.beat_cnt_o), 96'(44));
        idle_ticks(L + 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bram_read_align.md
BRAM_READ_ALIGN -- requirements
Module: bram_read_align

Interface
REQ-001 Parameter DATA_WIDTH, default 12, coefficient width per bank port.
REQ-002 Parameter BRAM_LAT, default 2, BRAM read latency in cycles (legal 1..4).
REQ-003 clk_i  in  1  single clock, all logic on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-low.
REQ-005 start_i  in  1  one-cycle pulse, begins a stage.
REQ-006 rd_valid_i  in  1  bank addresses issued to BRAM this cycle.
REQ-007 index_a_i  in  8x3  bank index per BU, port A (BU0 in LSBs).
REQ-008 index_b_i  in  8x3  bank index per BU, port B.
REQ-009 done_decode_i  in  1  one-cycle pulse, last address beat issued.
REQ-010 bram_dout_a_i  in  8xDATA_WIDTH  bank read data port A (bank0 in LSBs).
REQ-011 bram_dout_b_i  in  8xDATA_WIDTH  bank read data port B.
REQ-012 bu_a_o  out  8xDATA_WIDTH  port-A operand per BU, BU order.
REQ-013 bu_b_o  out  8xDATA_WIDTH  port-B operand per BU, BU order.
REQ-014 out_valid_o  out  1  bu_a_o/bu_b_o valid this cycle.
REQ-015 beat_cnt_o  out  8  accepted beats since start_i.
REQ-016 busy_o  out  1  high in any state other than IDLE.
REQ-017 conflict_o  out  1  sticky bank-conflict flag.
REQ-018 done_o  out  1  one-cycle pulse, stage fully drained.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; each state held by a registered state variable.
REQ-020 IDLE->RUN on start_i; start_i in any other state is ignored.
REQ-021 RUN: beat accepted when rd_valid_i=1; rd_valid_i in IDLE/DRAIN/DONE is ignored.
REQ-022 RUN->DRAIN on done_decode_i; rd_valid_i in that same cycle is still accepted.
REQ-023 DRAIN lasts exactly BRAM_LAT+1 cycles (down-counter), then DONE.
REQ-024 DONE lasts one cycle, asserts done_o, returns to IDLE.
REQ-025 Each accepted beat pushes {1, index_a_i, index_b_i} into a BRAM_LAT-deep shift pipe; non-accepted cycles push valid=0.
REQ-026 At pipe output, bu_a_o[i] = bram_dout_a_i[idx_a[i]], bu_b_o[i] = bram_dout_b_i[idx_b[i]], registered; out_valid_o = registered pipe valid.
REQ-027 Latency accepted beat -> out_valid_o is exactly BRAM_LAT+1 cycles; back-to-back beats give back-to-back outputs.
REQ-028 Several BUs selecting the same bank all receive that bank's data (broadcast, no error in routing).
REQ-029 When out_valid_o=0, bu_a_o/bu_b_o hold their last values.
REQ-030 beat_cnt_o cleared on start_i, +1 per accepted beat, wraps 255->0.
REQ-031 done_o asserts only after the last accepted beat's out_valid_o has been emitted.

Reset
REQ-032 rst_i low: state=IDLE, pipe valids=0, all outputs 0 (bu_a_o, bu_b_o, out_valid_o, beat_cnt_o, busy_o, conflict_o, done_o).
REQ-033 Reset mid-RUN/DRAIN aborts the stage; no out_valid_o or done_o from in-flight beats after release.

Configuration
REQ-034 Macro BRAM_CONFLICT_CHECK_EN defined: conflict_o set when an accepted beat has two equal entries within index_a_i or within index_b_i (A vs B equality is legal); cleared only by start_i or reset.
REQ-035 Macro undefined: no comparison logic, conflict_o tied 0.

Verification
REQ-036 BRAM_LAT=2, start_i, one beat index_a_i={7,6,5,4,3,2,1,0}, bank k returns data 0x100+k -> out_valid_o 3 cycles later, bu_a_o[0]=0x107, bu_a_o[7]=0x100.
REQ-037 16 consecutive beats then done_decode_i with the 16th -> 16 consecutive out_valid_o, beat_cnt_o=16, done_o one cycle after the last output's DRAIN end, busy_o low next cycle.
REQ-038 With BRAM_CONFLICT_CHECK_EN, beat index_a_i with BU0=BU3=bank 2 -> conflict_o=1 and held; next start_i clears it; index_a_i=index_b_i identical permutations -> conflict_o stays 0.
REQ-039 rst_i low for 1 cycle while 2 beats in flight -> no out_valid_o or done_o, all outputs 0, FSM IDLE.
REQ-040 rd_valid_i pulsed in IDLE and in DRAIN, start_i pulsed in RUN -> ignored: beat_cnt_o unchanged, no extra out_valid_o.
REQ-041 300 beats in one stage -> beat_cnt_o wraps to 44, outputs unaffected.
